// File: rtl/nx_axbs_arb_pkg.sv
// nx_axbs_arb_pkg
//   Shared types and constants for the nx_axbs_arb multiplier scheduler.
//   arb_state_e : drain/quiesce FSM states
//   STATS_W     : width of each per-requester grant counter (stats build only)
package nx_axbs_arb_pkg;

    localparam int STATS_W = 16;

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        DRAIN  = 2'd1,
        HALTED = 2'd2
    } arb_state_e;

endpackage

// File: rtl/nx_axbs_core.sv
// nx_axbs_core
//   Signed multiplier pipeline, CORE_LAT register stages from din to dout.
//   Data registers carry no reset; the caller qualifies dout with its own valid.
// Ports:
//   clk          : clock
//   din_a, din_b : signed operands (two's complement)
//   dout         : full-precision signed product, CORE_LAT cycles after din
module nx_axbs_core #(
    parameter int SIZE_A   = 15,
    parameter int SIZE_B   = 15,
    parameter int CORE_LAT = 6
) (
    input  logic                            clk,
    input  logic        [SIZE_A-1:0]        din_a,
    input  logic        [SIZE_B-1:0]        din_b,
    output logic signed [SIZE_A+SIZE_B-1:0] dout
);

    localparam int PW = SIZE_A + SIZE_B;

    logic signed [PW-1:0] w_a;
    logic signed [PW-1:0] w_b;
    logic signed [PW-1:0] w_prod;
    logic signed [PW-1:0] r_p [CORE_LAT];

    assign w_a    = PW'($signed(din_a));
    assign w_b    = PW'($signed(din_b));
    assign w_prod = w_a * w_b;

    always_ff @(posedge clk) begin
        r_p[0] <= w_prod;
        for (int i = 1; i < CORE_LAT; i++) begin
            r_p[i] <= r_p[i-1];
        end
    end

    assign dout = r_p[CORE_LAT-1];

endmodule

// File: rtl/nx_rr_arb.sv
// nx_rr_arb
//   Round-robin arbiter. The search for a requester starts at the pointer;
//   when a grant is taken the pointer moves to the position after the winner.
// Ports:
//   clk, rst_n : clock, async active-low reset (pointer returns to 0)
//   i_req      : request vector
//   i_adv      : grant was consumed this cycle, advance the pointer
//   o_grant    : one-hot grant (all zero when nothing requests)
//   o_ptr      : current pointer position
module nx_rr_arb #(
    parameter int NUM_REQ = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         i_req,
    input  logic                       i_adv,
    output logic [NUM_REQ-1:0]         o_grant,
    output logic [$clog2(NUM_REQ)-1:0] o_ptr
);

    localparam int PW = $clog2(NUM_REQ);

    logic [PW-1:0] r_ptr;
    logic [PW-1:0] w_idx;
    logic          w_found;

    always_comb begin
        o_grant = '0;
        w_idx   = '0;
        w_found = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!w_found && i_req[(int'(r_ptr) + k) % NUM_REQ]) begin
                w_found = 1'b1;
                w_idx   = PW'((int'(r_ptr) + k) % NUM_REQ);
                o_grant[(int'(r_ptr) + k) % NUM_REQ] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (i_adv && w_found) begin
            r_ptr <= (w_idx == PW'(NUM_REQ - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    assign o_ptr = r_ptr;

endmodule

// File: rtl/nx_axbs_arb.sv
// nx_axbs_arb
//   Round-robin scheduler sharing one nx_axbs_core multiplier among NUM_REQ
//   requesters. One operand pair is issued per cycle; a valid/tag pipe of
//   depth CORE_LAT+1 steers each product back to the requester that issued it.
//   A drain interface stops issue and reports when the pipe is empty.
// Build option:
//   NX_AXBS_ARB_STATS_EN : adds grant_cnt, one 16-bit saturating accept
//                          counter per requester (cleared only by rst_n).
// Ports:
//   clk, rst_n        : clock, async active-low reset
//   req_valid/ready   : per-requester handshake, at most one ready bit set
//   req_a, req_b      : packed operands, requester i in slice i
//   res_valid         : one-hot result strobe, no backpressure
//   res_data          : signed product shared by all requesters
//   drain_req         : level, stop issuing and empty the pipe
//   drain_done        : one-cycle pulse when the pipe is seen empty while draining
//   busy              : at least one product in flight
//
// state  | meaning
// RUN    | normal issue
// DRAIN  | no issue, waiting for in-flight products to retire
// HALTED | pipe empty, held until drain_req drops
module nx_axbs_arb
    import nx_axbs_arb_pkg::*;
#(
    parameter int NUM_REQ  = 4,
    parameter int SIZE_A   = 15,
    parameter int SIZE_B   = 15,
    parameter int CORE_LAT = 6
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic        [NUM_REQ-1:0]       req_valid,
    output logic        [NUM_REQ-1:0]       req_ready,
    input  logic        [NUM_REQ*SIZE_A-1:0] req_a,
    input  logic        [NUM_REQ*SIZE_B-1:0] req_b,
    output logic        [NUM_REQ-1:0]       res_valid,
    output logic signed [SIZE_A+SIZE_B-1:0] res_data,
    input  logic                            drain_req,
    output logic                            drain_done,
    output logic                            busy
`ifdef NX_AXBS_ARB_STATS_EN
    ,
    output logic [NUM_REQ*STATS_W-1:0]      grant_cnt
`endif
);

    localparam int PW = $clog2(NUM_REQ);
    localparam int IW = $clog2(CORE_LAT + 2);
    localparam int PD = CORE_LAT + 1;

    arb_state_e                     r_state;
    logic [NUM_REQ-1:0]             w_grant;
    logic [PW-1:0]                  w_ptr_unused;
    logic [PW-1:0]                  w_gidx;
    logic                           w_issue_ok;
    logic                           w_accept;
    logic                           w_res;
    logic [SIZE_A-1:0]              r_a;
    logic [SIZE_B-1:0]              r_b;
    logic signed [SIZE_A+SIZE_B-1:0] w_dout;
    logic [PD-1:0]                  r_vld;
    logic [PW-1:0]                  r_tag [PD];
    logic [IW-1:0]                  r_inflight;

    // Pointer is visible for debug only; nothing here consumes it.
    nx_rr_arb #(.NUM_REQ(NUM_REQ)) u_rr (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_req   (req_valid),
        .i_adv   (w_accept),
        .o_grant (w_grant),
        .o_ptr   (w_ptr_unused)
    );

    // rst_n gates ready so nothing is granted while reset is held.
    assign w_issue_ok = rst_n && (r_state == RUN) && !drain_req;
    assign req_ready  = w_issue_ok ? w_grant : '0;
    assign w_accept   = |req_ready;

    always_comb begin
        w_gidx = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (w_grant[k]) begin
                w_gidx = PW'(k);
            end
        end
    end

    // Core input stage: not reset, masked downstream by the valid pipe.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_a <= req_a[int'(w_gidx)*SIZE_A +: SIZE_A];
            r_b <= req_b[int'(w_gidx)*SIZE_B +: SIZE_B];
        end
    end

    nx_axbs_core #(
        .SIZE_A   (SIZE_A),
        .SIZE_B   (SIZE_B),
        .CORE_LAT (CORE_LAT)
    ) u_core (
        .clk   (clk),
        .din_a (r_a),
        .din_b (r_b),
        .dout  (w_dout)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_vld <= '0;
            for (int i = 0; i < PD; i++) begin
                r_tag[i] <= '0;
            end
        end else begin
            r_vld    <= {r_vld[PD-2:0], w_accept};
            r_tag[0] <= w_gidx;
            for (int i = 1; i < PD; i++) begin
                r_tag[i] <= r_tag[i-1];
            end
        end
    end

    assign w_res = r_vld[PD-1];

    always_comb begin
        res_valid = '0;
        if (w_res) begin
            res_valid[r_tag[PD-1]] = 1'b1;
        end
    end

    // Masking keeps the unreset core data off the output outside a strobe.
    assign res_data = w_res ? w_dout : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_accept, w_res})
                2'b10:   r_inflight <= r_inflight + 1'b1;
                2'b01:   r_inflight <= r_inflight - 1'b1;
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign busy = (r_inflight != '0);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= RUN;
        end else begin
            case (r_state)
                RUN:     if (drain_req) r_state <= DRAIN;
                DRAIN:   if (!drain_req) r_state <= RUN;
                         else if (r_inflight == '0) r_state <= HALTED;
                HALTED:  if (!drain_req) r_state <= RUN;
                default: r_state <= RUN;
            endcase
        end
    end

    // Decoded from state so the pulse lands in the first cycle the pipe is
    // seen empty, i.e. the cycle after the last strobe, never alongside one.
    assign drain_done = (r_state == DRAIN) && drain_req && (r_inflight == '0);

`ifdef NX_AXBS_ARB_STATS_EN
    for (genvar g = 0; g < NUM_REQ; g++) begin : g_stats
        logic [STATS_W-1:0] r_cnt;
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                r_cnt <= '0;
            end else if (req_ready[g] && (r_cnt != '1)) begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
        assign grant_cnt[g*STATS_W +: STATS_W] = r_cnt;
    end
`endif

endmodule

// File: tb/tb_nx_axbs_arb.sv
// tb_nx_axbs_arb
//   Bench for nx_axbs_arb at default parameters. A transaction-level model
//   (queue of scheduled results, round-robin pointer, drain mode) predicts
//   every output each cycle; directed sequences are followed by random traffic.
module tb_nx_axbs_arb;

    localparam int N   = 4;
    localparam int SA  = 15;
    localparam int SB  = 15;
    localparam int LAT = 6;

    logic                    clk = 1'b0;
    logic                    rst_n;
    logic [N-1:0]            req_valid;
    logic [N-1:0]            req_ready;
    logic [N*SA-1:0]         req_a;
    logic [N*SB-1:0]         req_b;
    logic [N-1:0]            res_valid;
    logic signed [SA+SB-1:0] res_data;
    logic                    drain_req;
    logic                    drain_done;
    logic                    busy;
`ifdef NX_AXBS_ARB_STATS_EN
    logic [N*16-1:0]         grant_cnt;
`endif

    always #5 clk = ~clk;

    nx_axbs_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .drain_req  (drain_req),
        .drain_done (drain_done),
        .busy       (busy)
`ifdef NX_AXBS_ARB_STATS_EN
        ,
        .grant_cnt  (grant_cnt)
`endif
    );

    typedef struct {
        int     due;
        int     tag;
        longint prod;
    } ent_t;

    ent_t                q[$];
    int                  cyc;
    int                  mptr;
    int                  mst;      // 0 issuing, 1 draining, 2 halted
    int                  n_vec;
    int                  n_err;
    int                  stat_m[N];
    logic signed [SA-1:0] av[N];
    logic signed [SB-1:0] bv[N];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic pack();
        for (int i = 0; i < N; i++) begin
            req_a[i*SA +: SA] = av[i];
            req_b[i*SB +: SB] = bv[i];
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            av[i] = 15'($urandom);
            bv[i] = 15'($urandom);
        end
    endtask

    // One clock cycle: entered just after a rising edge with inputs set.
    task automatic step();
        int           gi;
        logic [N-1:0] eg;
        logic [N-1:0] er;
        longint       ed;
        logic         edd;
        pack();
        @(negedge clk);
        gi = -1;
        if (mst == 0 && !drain_req) begin
            for (int k = 0; k < N; k++) begin
                int j;
                j = (mptr + k) % N;
                if (gi < 0 && req_valid[j]) gi = j;
            end
        end
        eg = '0;
        if (gi >= 0) eg[gi] = 1'b1;
        er = '0;
        ed = 0;
        if (q.size() > 0 && q[0].due == cyc) begin
            er[q[0].tag] = 1'b1;
            ed = q[0].prod;
        end
        edd = (mst == 1) && drain_req && (q.size() == 0);
        chk("req_ready", req_ready, eg);
        chk("res_valid", res_valid, er);
        if (er != '0) chk("res_data", res_data, ed);
        chk("busy", busy, q.size() != 0);
        chk("drain_done", drain_done, edd);
        @(posedge clk);
        if (er != '0) void'(q.pop_front());
        if (gi >= 0) begin
            q.push_back('{cyc + LAT + 1, gi, longint'(av[gi]) * longint'(bv[gi])});
            mptr = (gi + 1) % N;
            if (stat_m[gi] < 65535) stat_m[gi]++;
        end
        case (mst)
            0: if (drain_req) mst = 1;
            1: if (!drain_req) mst = 0; else if (edd) mst = 2;
            default: if (!drain_req) mst = 0;
        endcase
        cyc++;
        #1;
    endtask

    task automatic do_reset(input int ncyc);
        rst_n     = 1'b0;
        drain_req = 1'b0;
        req_valid = '1;
        repeat (ncyc) begin
            @(negedge clk);
            chk("rst_req_ready", req_ready, '0);
            chk("rst_res_valid", res_valid, '0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_drain_done", drain_done, 1'b0);
            chk("rst_res_data", res_data, 64'd0);
            @(posedge clk);
            #1;
        end
        q.delete();
        mptr      = 0;
        mst       = 0;
        rst_n     = 1'b1;
        req_valid = '0;
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        drain_req = 1'b0;
        cyc = 0; mptr = 0; mst = 0; n_vec = 0; n_err = 0;
        for (int i = 0; i < N; i++) begin
            av[i] = '0; bv[i] = '0; stat_m[i] = 0;
        end
        pack();
        @(posedge clk);
        #1;
        do_reset(3);

        // single product on requester 0
        av[0] = 15'sd3; bv[0] = -15'sd5; req_valid = 4'b0001;
        step();
        req_valid = '0;
        repeat (10) step();

        // all requesters, 8 back-to-back grants
        req_valid = 4'b1111;
        repeat (8) begin rand_ops(); step(); end
        req_valid = '0;
        repeat (9) step();

        // operand extremes
        req_valid = 4'b0001;
        av[0] = -15'sd16384; bv[0] = -15'sd16384; step();
        av[0] = 15'sd16383;  bv[0] = -15'sd16384; step();
        av[0] = 15'sd0;      bv[0] = -15'sd1;     step();
        req_valid = '0;
        repeat (9) step();

        // drain with three products in flight
        req_valid = 4'b1111;
        repeat (3) begin rand_ops(); step(); end
        drain_req = 1'b1;
        repeat (12) step();
        drain_req = 1'b0;
        repeat (3) step();
        req_valid = '0;
        repeat (9) step();

        // reset with five products in flight
        req_valid = 4'b1111;
        repeat (5) begin rand_ops(); step(); end
        do_reset(2);
        req_valid = 4'b1111;
        repeat (2) begin rand_ops(); step(); end
        req_valid = '0;
        repeat (10) step();

        // random traffic with drain toggling
        repeat (3000) begin
            rand_ops();
            req_valid = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 19) == 0) drain_req = ~drain_req;
            step();
        end
        drain_req = 1'b0;
        req_valid = '0;
        repeat (10) step();

`ifdef NX_AXBS_ARB_STATS_EN
        for (int i = 0; i < N; i++) chk("grant_cnt", grant_cnt[i*16 +: 16], stat_m[i]);
        req_valid = 4'b0100;
        repeat (70000) step();
        req_valid = '0;
        chk("grant_cnt_sat", grant_cnt[2*16 +: 16], 64'd65535);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
